// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and byte codes for the UART-to-bus command bridge.
package uart_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'h5A;
    localparam logic [7:0] RSP_ACK = 8'hAC;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    // Little-endian assembly: the newest byte enters the top and everything slides down.
    function automatic logic [31:0] shift_in(input logic [31:0] cur, input logic [7:0] b);
        return {b, cur[31:8]};
    endfunction

endpackage

// File: rtl/uart_bus_bridge_timeout.sv
// Bus-phase watchdog: counts cycles while run=1 and flags the last allowed cycle.
module uart_bus_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);
    import uart_bus_bridge_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_bus_bridge.sv
// UART FIFO command frames to 32-bit valid/ready bus master, with serial responses.
// Optional bus watchdog enabled by defining UART_BUS_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rd,
    input  logic        tx_full,
    output logic [7:0]  tx_wdata,
    output logic        tx_wr,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        busy
);
    import uart_bus_bridge_pkg::*;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        is_wr, is_wr_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic [31:0] resp, resp_nxt;
    logic        pop, push;
    logic        timed_out;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    uart_bus_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (state == BUS),
        .expired(timed_out)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign timed_out  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr     <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            resp      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_wr     <= is_wr_nxt;
            bus_addr  <= addr_nxt;
            bus_wdata <= wdata_nxt;
            resp      <= resp_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        is_wr_nxt = is_wr;
        addr_nxt  = bus_addr;
        wdata_nxt = bus_wdata;
        resp_nxt  = resp;
        pop       = 1'b0;
        push      = 1'b0;
        bus_valid = 1'b0;

        case (state)
            IDLE: begin
                pop = ~rx_empty;
                if (pop && (rx_rdata == CMD_WR || rx_rdata == CMD_RD)) begin
                    is_wr_nxt = (rx_rdata == CMD_WR);
                    cnt_nxt   = '0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                pop = ~rx_empty;
                if (pop) begin
                    addr_nxt = shift_in(bus_addr, rx_rdata);
                    cnt_nxt  = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = is_wr ? WDATA : BUS;
                end
            end
            WDATA: begin
                pop = ~rx_empty;
                if (pop) begin
                    wdata_nxt = shift_in(bus_wdata, rx_rdata);
                    cnt_nxt   = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = BUS;
                end
            end
            BUS: begin
                bus_valid = 1'b1;
                cnt_nxt   = '0;
                // A ready arriving on the expiry cycle still completes normally.
                if (bus_ready) begin
                    resp_nxt  = is_wr ? {24'h0, RSP_ACK} : bus_rdata;
                    state_nxt = RESP;
                end else if (timed_out) begin
                    resp_nxt  = {24'h0, RSP_ERR};
                    state_nxt = RESP;
                end
            end
            RESP: begin
                push = ~tx_full;
                if (push) begin
                    resp_nxt = {8'h0, resp[31:8]};
                    cnt_nxt  = cnt + 2'd1;
                    if (is_wr || cnt == 2'd3) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the current state, so they are masked while reset is held.
        if (rst) begin
            pop       = 1'b0;
            push      = 1'b0;
            bus_valid = 1'b0;
        end
    end

    assign rx_rd    = pop;
    assign tx_wr    = push;
    assign tx_wdata = resp[7:0];
    assign bus_we   = is_wr;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: RX FIFO / bus slave / TX FIFO models plus scenario tasks.
module tb_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_empty;
    logic [7:0]  rx_rdata;
    logic        rx_rd;
    logic        tx_full;
    logic [7:0]  tx_wdata;
    logic        tx_wr;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    logic [31:0] txn_addr[$];
    logic [31:0] txn_wdata[$];
    logic        txn_we[$];

    int   cyc = 0;
    int   last_pop_cyc = 0;
    int   last_ready_cyc = 0;
    int   valid_cycles = 0;
    int   wait_cnt = 0;
    int   ready_delay = 0;
    bit   ready_never = 0;
    bit   idle_ready = 0;
    int   tx_while_full = 0;
    int   pop_while_empty = 0;
    int   unstable = 0;
    bit   in_req = 0;
    bit   do_pop = 0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    uart_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .rx_rdata (rx_rdata),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_wdata (tx_wdata),
        .tx_wr    (tx_wr),
        .bus_valid(bus_valid),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // FIFO and bus-slave model: observe at negedge, update FIFO head just after posedge.
    initial begin : env_model
        rx_empty  = 1'b1;
        rx_rdata  = 8'h00;
        bus_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            do_pop = (rx_rd === 1'b1);
            if (do_pop && rx_empty) pop_while_empty++;
            if (do_pop) last_pop_cyc = cyc;
            if (tx_wr === 1'b1) begin
                if (tx_full) tx_while_full++;
                tx_q.push_back(tx_wdata);
                tx_cyc_q.push_back(cyc);
            end
            if (bus_valid === 1'b1) begin
                if (in_req && (bus_addr !== hold_addr || bus_wdata !== hold_wdata || bus_we !== hold_we))
                    unstable++;
                hold_addr  = bus_addr;
                hold_wdata = bus_wdata;
                hold_we    = bus_we;
                in_req     = 1'b1;
                valid_cycles++;
                bus_ready = !ready_never && (wait_cnt >= ready_delay);
                if (bus_ready) begin
                    txn_addr.push_back(bus_addr);
                    txn_wdata.push_back(bus_wdata);
                    txn_we.push_back(bus_we);
                    last_ready_cyc = cyc;
                    wait_cnt = 0;
                    in_req   = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_req    = 1'b0;
                wait_cnt  = 0;
                bus_ready = idle_ready;
            end
            @(posedge clk);
            #1;
            if (do_pop && rx_q.size() > 0) rx_q.delete(0);
            rx_empty = (rx_q.size() == 0);
            rx_rdata = rx_empty ? 8'h00 : rx_q[0];
        end
    end

    function automatic logic [31:0] q32(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [7:0] q8(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc_q.delete();
        txn_addr.delete();
        txn_wdata.delete();
        txn_we.delete();
        valid_cycles = 0;
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        rx_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
    endtask

    task automatic push_read(input logic [31:0] a);
        rx_q.push_back(8'h5A);
        for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rx_q.size() == 0 && rx_empty === 1'b1 && busy === 1'b0) && n < budget);
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy=%b rx_left=%0d budget=%0d", name, busy, rx_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        checks++;
        if ({rx_rd, tx_wr, bus_valid, bus_we, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=00000", {rx_rd, tx_wr, bus_valid, bus_we, busy});
        end
        checks++;
        if ({bus_addr, bus_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h_%h exp=0", bus_addr, bus_wdata);
        end
        checks++;
        if (tx_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_wdata got=%h exp=00", tx_wdata);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_write();
        clear_logs();
        ready_delay = 0; ready_never = 0; idle_ready = 1;
        push_write(32'h4000_0010, 32'hDEAD_BEEF);
        wait_done(200, "write");
        checks++;
        if (txn_addr.size() != 1 || q32(txn_addr, 0) !== 32'h4000_0010) begin
            failures++;
            $display("FAIL write_addr n=%0d got=%h exp=40000010", txn_addr.size(), q32(txn_addr, 0));
        end
        checks++;
        if (q32(txn_wdata, 0) !== 32'hDEAD_BEEF || txn_we.size() != 1 || txn_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL write_data got=%h exp=deadbeef", q32(txn_wdata, 0));
        end
        checks++;
        if (valid_cycles != 1) begin
            failures++;
            $display("FAIL write_valid_cycles got=%0d exp=1", valid_cycles);
        end
        checks++;
        if (tx_q.size() != 1 || q8(tx_q, 0) !== 8'hAC) begin
            failures++;
            $display("FAIL write_ack n=%0d got=%h exp=ac", tx_q.size(), q8(tx_q, 0));
        end
        checks++;
        if (tx_cyc_q.size() != 1 || tx_cyc_q[0] - last_pop_cyc != 2) begin
            failures++;
            $display("FAIL write_latency got=%0d exp=2", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - last_pop_cyc : -1);
        end
        idle_ready = 0;
    endtask

    task automatic test_read();
        logic [7:0] exp_b[4];
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        clear_logs();
        ready_delay = 5; ready_never = 0;
        bus_rdata = 32'h1234_5678;
        push_read(32'h4000_0004);
        wait_done(200, "read");
        checks++;
        if (txn_addr.size() != 1 || q32(txn_addr, 0) !== 32'h4000_0004 || txn_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL read_addr n=%0d got=%h exp=40000004 we=0", txn_addr.size(), q32(txn_addr, 0));
        end
        checks++;
        if (valid_cycles != 6) begin
            failures++;
            $display("FAIL read_valid_cycles got=%0d exp=6", valid_cycles);
        end
        checks++;
        if (tx_cyc_q.size() == 0 || tx_cyc_q[0] - last_ready_cyc != 1) begin
            failures++;
            $display("FAIL read_first_byte_latency got=%0d exp=1", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - last_ready_cyc : -1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q8(tx_q, i) !== exp_b[i]) begin
                failures++;
                $display("FAIL read_byte%0d got=%h exp=%h", i, q8(tx_q, i), exp_b[i]);
            end
        end
        ready_delay = 0;
    endtask

    task automatic test_discard();
        logic [7:0] exp_b[4];
        exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        clear_logs();
        ready_delay = 1;
        bus_rdata = 32'hCAFE_F00D;
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        push_read(32'h4000_0008);
        wait_done(200, "discard");
        checks++;
        if (txn_addr.size() != 1 || q32(txn_addr, 0) !== 32'h4000_0008) begin
            failures++;
            $display("FAIL discard_addr n=%0d got=%h exp=40000008", txn_addr.size(), q32(txn_addr, 0));
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_q.size() != 4 || q8(tx_q, i) !== exp_b[i]) begin
                failures++;
                $display("FAIL discard_byte%0d got=%h exp=%h", i, q8(tx_q, i), exp_b[i]);
            end
        end
        ready_delay = 0;
    endtask

    task automatic test_tx_full();
        logic [7:0] exp_b[4];
        int n;
        exp_b = '{8'hDE, 8'hC0, 8'hAD, 8'h0B};
        clear_logs();
        tx_while_full = 0;
        bus_rdata = 32'h0BAD_C0DE;
        tx_full = 1'b1;
        push_read(32'h4000_000C);
        n = 0;
        while (txn_addr.size() == 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(10);
        checks++;
        if (tx_q.size() != 0 || tx_while_full != 0) begin
            failures++;
            $display("FAIL txfull_stall pushes=%0d exp=0", tx_q.size());
        end
        tx_full = 1'b0;
        wait_done(100, "txfull");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q8(tx_q, i) !== exp_b[i]) begin
                failures++;
                $display("FAIL txfull_byte%0d got=%h exp=%h", i, q8(tx_q, i), exp_b[i]);
            end
        end
        checks++;
        if (tx_cyc_q.size() != 4 || tx_cyc_q[3] - tx_cyc_q[0] != 3) begin
            failures++;
            $display("FAIL txfull_burst n=%0d exp=4 consecutive", tx_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        tick(8);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_rd, tx_wr, bus_valid, bus_we, busy, tx_wdata, bus_addr, bus_wdata} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs busy=%b addr=%h exp=all0", busy, bus_addr);
        end
        push_write(32'h4000_0020, 32'h0102_0304);
        wait_done(200, "midreset");
        checks++;
        if (txn_addr.size() != 1 || q32(txn_addr, 0) !== 32'h4000_0020 || q32(txn_wdata, 0) !== 32'h0102_0304) begin
            failures++;
            $display("FAIL midreset_second n=%0d got=%h/%h exp=40000020/01020304",
                     txn_addr.size(), q32(txn_addr, 0), q32(txn_wdata, 0));
        end
        checks++;
        if (tx_q.size() != 1 || q8(tx_q, 0) !== 8'hAC) begin
            failures++;
            $display("FAIL midreset_ack got=%h exp=ac", q8(tx_q, 0));
        end
    endtask

    task automatic test_abandon();
        int n;
        clear_logs();
        ready_never = 1;
        push_write(32'h4000_0030, 32'hFFFF_0000);
        n = 0;
        while (bus_valid !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b0 || busy !== 1'b0 || valid_cycles < 3) begin
            failures++;
            $display("FAIL abandon_valid got=%b busy=%b seen=%0d exp=0,0,>=3", bus_valid, busy, valid_cycles);
        end
        tick(3);
        checks++;
        if (tx_q.size() != 0 || txn_addr.size() != 0) begin
            failures++;
            $display("FAIL abandon_residue tx=%0d txn=%0d exp=0,0", tx_q.size(), txn_addr.size());
        end
        ready_never = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[5];
        exp_b = '{8'hAC, 8'hCC, 8'h33, 8'hAA, 8'h55};
        clear_logs();
        bus_rdata = 32'h55AA_33CC;
        push_write(32'h4000_0040, 32'h1111_2222);
        push_read(32'h4000_0044);
        wait_done(300, "b2b");
        checks++;
        if (txn_addr.size() != 2 || q32(txn_addr, 0) !== 32'h4000_0040 || q32(txn_addr, 1) !== 32'h4000_0044
            || txn_we[0] !== 1'b1 || txn_we[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_txns n=%0d a0=%h a1=%h exp=40000040(w),40000044(r)",
                     txn_addr.size(), q32(txn_addr, 0), q32(txn_addr, 1));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_q.size() != 5 || q8(tx_q, i) !== exp_b[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, q8(tx_q, i), exp_b[i]);
            end
        end
    endtask

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp_b[4];
        exp_b = '{8'hEE, 8'h00, 8'h00, 8'h00};
        clear_logs();
        ready_never = 1;
        push_write(32'h4000_0050, 32'h0000_0001);
        wait_done(200, "timeout_wr");
        checks++;
        if (valid_cycles != 16 || tx_q.size() != 1 || q8(tx_q, 0) !== 8'hEE) begin
            failures++;
            $display("FAIL timeout_write valid=%0d exp=16 resp=%h exp=ee", valid_cycles, q8(tx_q, 0));
        end
        clear_logs();
        push_read(32'h4000_0054);
        wait_done(200, "timeout_rd");
        checks++;
        if (valid_cycles != 16) begin
            failures++;
            $display("FAIL timeout_read_valid got=%0d exp=16", valid_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_q.size() != 4 || q8(tx_q, i) !== exp_b[i]) begin
                failures++;
                $display("FAIL timeout_read_byte%0d got=%h exp=%h", i, q8(tx_q, i), exp_b[i]);
            end
        end
        ready_never = 0;
    endtask
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst       = 1'b1;
        tx_full   = 1'b0;
        bus_rdata = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_discard();
        test_tx_full();
        test_reset_mid();
        test_abandon();
        test_back_to_back();
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (unstable != 0 || pop_while_empty != 0) begin
            failures++;
            $display("FAIL protocol unstable=%0d pop_empty=%0d exp=0,0", unstable, pop_while_empty);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
